gmii_rx_frame_buffer: RTL and testbench
=======================================

Name: gmii_rx_frame_buffer

Overview:
- Parametrised GMII receive capture block for the ethrecv design. It supersedes the single-buffer, free-running byte capture.
- Strips preamble/SFD and validates frame boundaries.
- Stores complete frames into a ring of 2^SLOT_W RAM slots, each with its length and a valid flag.
- Provides a registered random-access read port plus slot release for the host/LED/debug logic, and statistics counters.
- Top level drives clock from the PHY receive clock.

Parameters:
- ADDR_W, 11: byte address width per slot; slot capacity is 2^ADDR_W bytes.
- SLOT_W, 1: slot index width; 2^SLOT_W frame slots.
- CNT_W, 16: width of the statistics counters.

Ports:
- clock  in  1  PHY receive clock; all logic on its rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- rx_dv  in  1  GMII receive data valid.
- rx_er  in  1  GMII receive error.
- rx_data  in  8  GMII receive byte.
- rd_slot  in  SLOT_W  Read slot select.
- rd_addr  in  ADDR_W  Read byte address within the slot.
- rd_data  out  8  Registered read byte.
- rd_len  out  ADDR_W+1  Registered length of rd_slot.
- release  in  1  One-cycle pulse; frees rel_slot.
- rel_slot  in  SLOT_W  Slot to free.
- slot_valid  out  2^SLOT_W  Per-slot "holds committed frame".
- frame_cnt  out  CNT_W  Committed frames.
- drop_cnt  out  CNT_W  Frames dropped because no slot was free.
- err_cnt  out  CNT_W  Frames discarded for rx_er, bad preamble, oversize, or empty payload.
- crc_err_cnt  out  CNT_W  FCS failures; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; wr_slot=0; wr_ptr=0; all slot_valid=0; all counters=0; rd_data=0; rd_len=0. RAM contents are not reset.
- IDLE:
  - rx_dv&&rx_data==8'h55 -> PREAMBLE.
  - rx_dv with any other byte -> DROP, err_cnt+1.
- PREAMBLE:
  - rx_dv&&8'h55 -> stay.
  - rx_dv&&8'hD5: if slot_valid[wr_slot]==0 -> DATA with wr_ptr=0; else -> DROP, drop_cnt+1.
  - rx_dv with another byte -> DROP, err_cnt+1.
  - !rx_dv -> IDLE with no count.
- DATA:
  - Each rx_dv cycle writes rx_data to RAM[wr_slot][wr_ptr] and increments wr_ptr.
  - rx_er while rx_dv -> DROP, err_cnt+1, no commit.
  - A byte arriving when wr_ptr==2^ADDR_W (oversize) -> DROP, err_cnt+1.
  - !rx_dv with wr_ptr>0 -> commit: len[wr_slot]=wr_ptr, slot_valid[wr_slot]=1, wr_slot+1 (wraps modulo 2^SLOT_W), frame_cnt+1, -> IDLE.
  - !rx_dv with wr_ptr==0 -> IDLE, err_cnt+1.
- DROP: wait for !rx_dv, then -> IDLE.
- Release:
  - release clears slot_valid[rel_slot] on the next edge.
  - Releasing an invalid slot has no effect.
  - A commit and a release of different slots in the same cycle both take effect.
  - A release of wr_slot while in PREAMBLE is seen by the SFD check in the following cycle.
- Read latency is 1 cycle: rd_data/rd_len reflect rd_slot/rd_addr sampled at the previous edge. Reading a slot being written returns RAM content without ordering guarantee.
- Counters saturate at all-ones; no wrap.
- Frames are committed in order; the host releases them in ring order to keep ordering.

Optional Feature:
- Macro RX_CRC_CHECK_EN.
- Defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over all DATA bytes.
  - At commit, the residue must equal 0xC704DD7B. On mismatch: no commit, crc_err_cnt+1, slot stays free.
  - Length still includes the 4 FCS bytes.
- Not defined: no CRC logic; crc_err_cnt tied to 0; every otherwise-valid frame commits.

Decomposition:
- Package gmii_rx_pkg holds:
  - state enum (IDLE, PREAMBLE, DATA, DROP);
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
  - CRC_POLY, CRC_INIT, CRC_RESIDUE.
- Sub-module crc32_d8: combinational next-CRC for one byte, instantiated only under RX_CRC_CHECK_EN.
- RAM is inferred inside the block as one memory of 2^(SLOT_W+ADDR_W) bytes.

Test Plan:
- Basic frame:
  - Stimulus: 7x55, D5, then 60 bytes 0x00..0x3B, dv low.
  - Response: slot_valid=2'b01, frame_cnt=1; rd_slot=0, rd_addr=5 -> rd_data=0x05 and rd_len=60 one cycle later.
- Full ring:
  - Stimulus: two frames, then a third; release slot 0; fourth frame.
  - Response: third frame gives drop_cnt=1 and slot_valid=2'b11. Fourth frame lands in slot 0, frame_cnt=3.
- rx_er:
  - Stimulus: rx_er high at payload byte 10.
  - Response: err_cnt=1, slot_valid unchanged, wr_slot unchanged; next good frame uses the same slot.
- Oversize:
  - Stimulus: payload of 2049 bytes (ADDR_W=11).
  - Response: err_cnt=1, no commit. Then an SFD immediately followed by dv low gives err_cnt=2.
- Reset mid-frame:
  - Stimulus: reset_n low at payload byte 20 with dv held high, then released.
  - Response: all outputs 0. Remaining bytes (non-0x55) -> DROP, err_cnt=1; next frame commits to slot 0.
- CRC (RX_CRC_CHECK_EN):
  - Stimulus: 64-byte frame with correct FCS; then the same frame with one bit flipped.
  - Response: first commits with rd_len=64. Second gives crc_err_cnt=1 with frame_cnt unchanged.

Source files
------------

// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive frame buffer.
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    // Bit-reverse; the CRC runs LSB-first so constants are used in reflected form.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gmii_rx_frame_buffer_crc32_d8.sv
// Combinational reflected CRC-32 update for one byte.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out_c
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

    always_comb begin
        crc_out_c = crc_in ^ {24'h0, data_in};
        for (int i = 0; i < 8; i++) begin
            crc_out_c = crc_out_c[0] ? ((crc_out_c >> 1) ^ POLY_REFL) : (crc_out_c >> 1);
        end
    end

endmodule

// File: rtl/gmii_rx_frame_buffer.sv
// GMII receive capture into a ring of frame slots with read port and statistics.
// Optional FCS checking is enabled by defining RX_CRC_CHECK_EN. The release strobe is named slot_release since release is a reserved word.
module gmii_rx_frame_buffer
    import gmii_rx_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned SLOT_W = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   rx_dv,
    input  logic                   rx_er,
    input  logic [7:0]             rx_data,
    input  logic [SLOT_W-1:0]      rd_slot,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [7:0]             rd_data,
    output logic [ADDR_W:0]        rd_len,
    input  logic                   slot_release,
    input  logic [SLOT_W-1:0]      rel_slot,
    output logic [2**SLOT_W-1:0]   slot_valid,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       crc_err_cnt
);

    localparam int unsigned NSLOT      = 2**SLOT_W;
    localparam int unsigned MEM_W      = SLOT_W + ADDR_W;
    localparam int unsigned SLOT_BYTES = 2**ADDR_W;
    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(SLOT_BYTES);

    rx_state_e                     state_q, state_d;
    logic [SLOT_W-1:0]             wr_slot_q, wr_slot_d;
    logic [ADDR_W:0]               wr_ptr_q, wr_ptr_d;
    logic [NSLOT-1:0]              valid_q, valid_d;
    logic [NSLOT-1:0][ADDR_W:0]    len_q, len_d;
    logic [CNT_W-1:0]              frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]              drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]              err_cnt_q, err_cnt_d;
    logic [7:0]                    rd_data_q, rd_data_d;
    logic [ADDR_W:0]               rd_len_q, rd_len_d;
    logic                          mem_we_c;
    logic                          commit_c;

    logic [7:0] mem [2**MEM_W];

`ifdef RX_CRC_CHECK_EN
    localparam logic [31:0] CRC_CHECK = reflect32(CRC_RESIDUE);
    logic [31:0]      crc_q, crc_d, crc_next_c;
    logic [CNT_W-1:0] crc_err_cnt_q, crc_err_cnt_d;

    crc32_d8 u_crc (
        .crc_in    (crc_q),
        .data_in   (rx_data),
        .crc_out_c (crc_next_c)
    );
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Receive FSM, slot bookkeeping and counters.
    always_comb begin
        state_d     = state_q;
        wr_slot_d   = wr_slot_q;
        wr_ptr_d    = wr_ptr_q;
        valid_d     = valid_q;
        len_d       = len_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        err_cnt_d   = err_cnt_q;
        mem_we_c    = 1'b0;
        commit_c    = 1'b0;
`ifdef RX_CRC_CHECK_EN
        crc_d         = crc_q;
        crc_err_cnt_d = crc_err_cnt_q;
`endif
        rd_data_d   = mem[{rd_slot, rd_addr}];
        rd_len_d    = len_q[rd_slot];

        if (slot_release) begin
            valid_d[rel_slot] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    if (rx_data == PREAMBLE_BYTE) begin
                        state_d = PREAMBLE;
                    end else begin
                        state_d   = DROP;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                end
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end else if (rx_data == SFD_BYTE) begin
                    if (!valid_q[wr_slot_q]) begin
                        state_d  = DATA;
                        wr_ptr_d = '0;
`ifdef RX_CRC_CHECK_EN
                        crc_d    = CRC_INIT;
`endif
                    end else begin
                        state_d    = DROP;
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end
                end else if (rx_data != PREAMBLE_BYTE) begin
                    state_d   = DROP;
                    err_cnt_d = sat_inc(err_cnt_q);
                end
            end
            DATA: begin
                if (rx_dv) begin
                    if (rx_er || (wr_ptr_q == PTR_FULL)) begin
                        state_d   = DROP;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else begin
                        mem_we_c = 1'b1;
                        wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
`ifdef RX_CRC_CHECK_EN
                        crc_d    = crc_next_c;
`endif
                    end
                end else begin
                    state_d = IDLE;
                    if (wr_ptr_q == '0) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else begin
`ifdef RX_CRC_CHECK_EN
                        if (crc_q != CRC_CHECK) begin
                            crc_err_cnt_d = sat_inc(crc_err_cnt_q);
                        end else begin
                            commit_c = 1'b1;
                        end
`else
                        commit_c = 1'b1;
`endif
                    end
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Commit is applied after release so a same-cycle set of wr_slot wins.
        if (commit_c) begin
            len_d[wr_slot_q]   = wr_ptr_q;
            valid_d[wr_slot_q] = 1'b1;
            wr_slot_d          = wr_slot_q + SLOT_W'(1);
            frame_cnt_d        = sat_inc(frame_cnt_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_slot_q   <= '0;
            wr_ptr_q    <= '0;
            valid_q     <= '0;
            len_q       <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
            rd_data_q   <= '0;
            rd_len_q    <= '0;
`ifdef RX_CRC_CHECK_EN
            crc_q         <= CRC_INIT;
            crc_err_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_slot_q   <= wr_slot_d;
            wr_ptr_q    <= wr_ptr_d;
            valid_q     <= valid_d;
            len_q       <= len_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_cnt_q   <= err_cnt_d;
            rd_data_q   <= rd_data_d;
            rd_len_q    <= rd_len_d;
`ifdef RX_CRC_CHECK_EN
            crc_q         <= crc_d;
            crc_err_cnt_q <= crc_err_cnt_d;
`endif
        end
    end

    // Frame RAM has no reset.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem[{wr_slot_q, wr_ptr_q[ADDR_W-1:0]}] <= rx_data;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_len     = rd_len_q;
    assign slot_valid = valid_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign err_cnt    = err_cnt_q;
`ifdef RX_CRC_CHECK_EN
    assign crc_err_cnt = crc_err_cnt_q;
`else
    assign crc_err_cnt = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_frame_buffer.sv
// Randomized frame-level bench for gmii_rx_frame_buffer with a burst-outcome reference model.
`timescale 1ns/1ps
module tb_gmii_rx_frame_buffer;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned SLOT_W = 1;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned NSLOT  = 2;
    localparam int unsigned CAP    = 2048;
    localparam int          CMAX   = 65535;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                rx_dv = 1'b0;
    logic                rx_er = 1'b0;
    logic [7:0]          rx_data = 8'h00;
    logic [SLOT_W-1:0]   rd_slot = '0;
    logic [ADDR_W-1:0]   rd_addr = '0;
    logic                slot_release = 1'b0;
    logic [SLOT_W-1:0]   rel_slot = '0;
    logic [7:0]          rd_data;
    logic [ADDR_W:0]     rd_len;
    logic [NSLOT-1:0]    slot_valid;
    logic [CNT_W-1:0]    frame_cnt, drop_cnt, err_cnt, crc_err_cnt;

    gmii_rx_frame_buffer #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx_dv        (rx_dv),
        .rx_er        (rx_er),
        .rx_data      (rx_data),
        .rd_slot      (rd_slot),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_len       (rd_len),
        .slot_release (slot_release),
        .rel_slot     (rel_slot),
        .slot_valid   (slot_valid),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt),
        .err_cnt      (err_cnt),
        .crc_err_cnt  (crc_err_cnt)
    );

    always #4 clock = ~clock;

    // Reference model state: committed slots, their bytes, and counters.
    bit           m_valid [NSLOT];
    int           m_len   [NSLOT];
    byte unsigned m_mem   [NSLOT][$];
    int           m_wr_slot, m_frame, m_drop, m_err, m_crc;

    int  n_chk = 0, n_pass = 0;
    bit  chk_en = 1'b0, rd_rand = 1'b0;
    int  cap_slot, cap_addr;
    bit  cap_valid;

    byte unsigned pay[$];
    byte unsigned bq[$];
    bit           eq[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic bit [31:0] crc32(input byte unsigned d[$], input int n);
        bit [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            c = c ^ {24'h0, d[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit fcs_ok(input byte unsigned p[$]);
        int n;
        n = p.size();
        if (n < 4) return 1'b0;
        return crc32(p, n - 4) == {p[n-1], p[n-2], p[n-3], p[n-4]};
    endfunction

    function automatic logic [NSLOT-1:0] model_vec();
        logic [NSLOT-1:0] v;
        for (int k = 0; k < NSLOT; k++) v[k] = m_valid[k];
        return v;
    endfunction

    // Outcome of one contiguous rx_dv burst, judged from the whole byte list.
    function automatic void model_burst();
        int i, n;
        byte unsigned p[$];
        i = 0;
        n = bq.size();
        if (n == 0) return;
        if (bq[0] != 8'h55) begin m_err = sat(m_err); return; end
        while (i < n && bq[i] == 8'h55) i++;
        if (i == n) return;
        if (bq[i] != 8'hD5) begin m_err = sat(m_err); return; end
        if (m_valid[m_wr_slot]) begin m_drop = sat(m_drop); return; end
        i++;
        for (int j = i; j < n; j++) begin
            if (eq[j] || (j - i) >= CAP) begin m_err = sat(m_err); return; end
            p.push_back(bq[j]);
        end
        if (p.size() == 0) begin m_err = sat(m_err); return; end
`ifdef RX_CRC_CHECK_EN
        if (!fcs_ok(p)) begin m_crc = sat(m_crc); return; end
`endif
        m_mem[m_wr_slot] = p;
        m_len[m_wr_slot] = p.size();
        m_valid[m_wr_slot] = 1'b1;
        m_wr_slot = (m_wr_slot + 1) % NSLOT;
        m_frame = sat(m_frame);
    endfunction

    always @(posedge clock) begin
        cap_slot  <= int'(rd_slot);
        cap_addr  <= int'(rd_addr);
        cap_valid <= m_valid[rd_slot];
    end

    // Every settled cycle: full output state against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("slot_valid", slot_valid, model_vec());
            check("frame_cnt", frame_cnt, m_frame);
            check("drop_cnt", drop_cnt, m_drop);
            check("err_cnt", err_cnt, m_err);
            check("crc_err_cnt", crc_err_cnt, m_crc);
            if (cap_valid && m_valid[cap_slot]) begin
                check("rd_len", rd_len, m_len[cap_slot]);
                if (cap_addr < m_len[cap_slot]) check("rd_data", rd_data, m_mem[cap_slot][cap_addr]);
            end
        end
    end

    task automatic drive(input bit dv, input bit er, input byte unsigned d);
        int s;
        rx_dv = dv; rx_er = er; rx_data = d;
        if (rd_rand) begin
            s = $urandom_range(0, NSLOT - 1);
            rd_slot = SLOT_W'(s);
            rd_addr = ADDR_W'($urandom_range(0, m_len[s]));
        end
        @(posedge clock); #1;
    endtask

    task automatic gap(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic rel(input int s);
        slot_release = 1'b1; rel_slot = SLOT_W'(s);
        drive(1'b0, 1'b0, 8'h00);
        slot_release = 1'b0;
        m_valid[s] = 1'b0;
    endtask

    task automatic make_pay(input int nd, input bit incr);
        pay = {};
        for (int k = 0; k < nd; k++) pay.push_back(incr ? 8'(k) : 8'($urandom_range(0, 255)));
    endtask

    task automatic add_fcs();
        bit [31:0] c;
        c = crc32(pay, pay.size());
        for (int k = 0; k < 4; k++) pay.push_back(c[8*k +: 8]);
    endtask

    task automatic build(input int npre);
        bq = {}; eq = {};
        repeat (npre) bq.push_back(8'h55);
        bq.push_back(8'hD5);
        foreach (pay[k]) bq.push_back(pay[k]);
        foreach (bq[k]) eq.push_back(1'b0);
    endtask

    task automatic send_burst();
        chk_en = 1'b0;
        foreach (bq[i]) drive(1'b1, eq[i], bq[i]);
        drive(1'b0, 1'b0, 8'h00);
        model_burst();
        chk_en = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_slot_valid"}, slot_valid, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_crc_err_cnt"}, crc_err_cnt, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_len"}, rd_len, 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NSLOT; k++) m_valid[k] = 1'b0;
        m_wr_slot = 0; m_frame = 0; m_drop = 0; m_err = 0; m_crc = 0;
    endtask

    initial begin
        int kind, npre, nd;
        model_reset();
        for (int k = 0; k < NSLOT; k++) m_len[k] = 0;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        chk_en = 1'b1;
        rd_rand = 1'b1;
        gap(2);

`ifndef RX_CRC_CHECK_EN
        // Basic frame and registered read.
        make_pay(60, 1'b1); build(7); send_burst(); gap(1);
        check("basic_slot_valid", slot_valid, 2'b01);
        check("basic_frame_cnt", frame_cnt, 1);
        rd_rand = 1'b0; rd_slot = '0; rd_addr = ADDR_W'(5);
        gap(1);
        check("basic_rd_data", rd_data, 8'h05);
        check("basic_rd_len", rd_len, 60);
        rd_rand = 1'b1;

        // Full ring.
        make_pay(40, 1'b0); build(7); send_burst(); gap(1);
        make_pay(25, 1'b0); build(7); send_burst(); gap(1);
        check("ring_drop_cnt", drop_cnt, 1);
        check("ring_slot_valid", slot_valid, 2'b11);
        rel(0);
        make_pay(33, 1'b0); build(7); send_burst(); gap(1);
        check("ring_frame_cnt", frame_cnt, 3);
        check("ring_slot0_refill", slot_valid, 2'b11);

        // rx_er on payload byte 10, then a good frame reuses the slot.
        rel(1); rel(0);
        make_pay(30, 1'b0); build(7); eq[8 + 10] = 1'b1; send_burst(); gap(1);
        check("er_err_cnt", err_cnt, 1);
        check("er_slot_valid", slot_valid, 2'b00);
        make_pay(20, 1'b0); build(7); send_burst(); gap(1);
        check("er_next_slot", slot_valid, 2'b10);
        check("er_frame_cnt", frame_cnt, 4);

        // Oversize payload, then an SFD with empty payload.
        rel(1);
        make_pay(CAP + 1, 1'b0); build(7); send_burst(); gap(1);
        check("over_err_cnt", err_cnt, 2);
        check("over_no_commit", slot_valid, 2'b00);
        pay = {}; build(7); send_burst(); gap(1);
        check("empty_err_cnt", err_cnt, 3);
        check("empty_frame_cnt", frame_cnt, 4);
`else
        // Good FCS commits with length including FCS; one flipped bit is rejected.
        make_pay(60, 1'b1); add_fcs(); build(7); send_burst(); gap(1);
        rd_rand = 1'b0; rd_slot = '0; rd_addr = '0;
        gap(1);
        check("crc_good_rd_len", rd_len, 64);
        check("crc_good_frame_cnt", frame_cnt, 1);
        rd_rand = 1'b1;
        make_pay(60, 1'b1); add_fcs(); pay[10] = pay[10] ^ 8'h04; build(7); send_burst(); gap(1);
        check("crc_bad_crc_err_cnt", crc_err_cnt, 1);
        check("crc_bad_frame_cnt", frame_cnt, 1);
        rel(0);
`endif

        // Randomized traffic with releases in the gaps.
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 99);
            npre = $urandom_range(1, 8);
            nd   = $urandom_range(1, 60);
            make_pay(nd, 1'b0); add_fcs(); build(npre);
            if (kind < 5) begin
                bq[0] = 8'h3C ^ 8'($urandom_range(0, 3));
            end else if (kind < 10) begin
                bq = {}; eq = {};
                repeat (npre) begin bq.push_back(8'h55); eq.push_back(1'b0); end
            end else if (kind < 15) begin
                bq[npre] = 8'h5D;
            end else if (kind < 20) begin
                pay = {}; build(npre);
            end else if (kind < 30) begin
                eq[npre + 1 + $urandom_range(0, nd - 1)] = 1'b1;
            end else if (kind < 36) begin
                bq[npre + 1 + $urandom_range(0, nd - 1)] ^= 8'(1 << $urandom_range(0, 7));
            end
            send_burst();
            if ($urandom_range(0, 9) < 6) rel($urandom_range(0, NSLOT - 1));
            gap($urandom_range(1, 3));
        end

        // Reset in the middle of a payload with rx_dv held high.
        rel(0); rel(1);
        make_pay(40, 1'b1); build(7);
        chk_en = 1'b0;
        for (int i = 0; i < 28; i++) drive(1'b1, 1'b0, bq[i]);
        rx_dv = 1'b1; rx_data = bq[28];
        reset_n = 1'b0;
        #2;
        check_zero("midreset");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        begin
            byte unsigned rest[$];
            for (int i = 28; i < bq.size(); i++) rest.push_back(bq[i]);
            bq = rest; eq = {};
            foreach (bq[k]) eq.push_back(1'b0);
        end
        send_burst(); gap(1);
        check("midreset_err_cnt", err_cnt, 1);
        make_pay(30, 1'b0); add_fcs(); build(7); send_burst(); gap(1);
        check("midreset_slot_valid", slot_valid, 2'b01);
        check("midreset_frame_cnt", frame_cnt, 1);
        gap(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
